// File: rtl/bus_arb_8.sv
// Eight-way round-robin bus arbiter. A grant is held for up to MAX_BURST
// accepted beats or until the owner drops its request. On release it re-arbitrates at once.
module bus_arb_8 #(
  parameter int MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  input  logic       ready,
  output logic [7:0] gnt,
  output logic [2:0] sel,
  output logic       valid,
  output logic [7:0] beat_cnt
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] LAST_BEAT = 8'(MAX_BURST - 1);

  state_t     state;
  logic [2:0] owner;
  logic [2:0] ptr;
  logic [2:0] next_ptr;
  logic [2:0] pick_idle;
  logic [2:0] pick_rel;
  logic       transfer;
  logic       release_now;

  // First requester at or after p, wrapping modulo 8. The scan runs from the
  // farthest offset down, so the nearest requester is the last to overwrite.
  function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
    logic [2:0] idx;
    rr_pick = p;
    for (int i = 7; i >= 0; i--) begin
      idx = p + 3'(i);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  assign valid       = (state == GRANT) && req[owner];
  assign transfer    = valid && ready;
  assign release_now = (state == GRANT) &&
                       (!req[owner] || (transfer && (beat_cnt == LAST_BEAT)));
  assign next_ptr    = owner + 3'd1;
  assign pick_idle   = rr_pick(req, ptr);
  assign pick_rel    = rr_pick(req, next_ptr);
  assign sel         = owner;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      owner    <= 3'd0;
      ptr      <= 3'd0;
      beat_cnt <= 8'd0;
      gnt      <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            state    <= GRANT;
            owner    <= pick_idle;
            gnt      <= 8'h01 << pick_idle;
            beat_cnt <= 8'd0;
          end
        end
        GRANT: begin
          if (release_now) begin
            ptr      <= next_ptr;
            beat_cnt <= 8'd0;
            if (|req) begin
              owner <= pick_rel;
              gnt   <= 8'h01 << pick_rel;
            end else begin
              state <= IDLE;
              gnt   <= 8'h00;
            end
          end else if (transfer) begin
            beat_cnt <= beat_cnt + 8'd1;
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= 8'h00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arb_8.sv
// Directed bench for bus_arb_8: a vector table for the single-owner flow plus
// hand sequences for round-robin rotation, reset mid-burst and MAX_BURST=1.
module tb_bus_arb_8;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] req, req1;
  logic       ready, ready1;
  logic [7:0] gnt, gnt1;
  logic [2:0] sel, sel1;
  logic       valid, valid1;
  logic [7:0] beat_cnt, beat_cnt1;

  int n_checks = 0;
  int n_err    = 0;

  bus_arb_8 #(.MAX_BURST(4)) dut (
    .clk(clk), .reset(reset), .req(req), .ready(ready),
    .gnt(gnt), .sel(sel), .valid(valid), .beat_cnt(beat_cnt)
  );

  bus_arb_8 #(.MAX_BURST(1)) dut1 (
    .clk(clk), .reset(reset), .req(req1), .ready(ready1),
    .gnt(gnt1), .sel(sel1), .valid(valid1), .beat_cnt(beat_cnt1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] req;
    logic       ready;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       valid;
    logic [7:0] beat;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // req, ready -> gnt, sel, valid, beat_cnt after the next edge
    tbl[0]  = '{8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 8'd0};
    tbl[1]  = '{8'h10, 1'b1, 8'h10, 3'd4, 1'b1, 8'd0};
    tbl[2]  = '{8'h10, 1'b1, 8'h10, 3'd4, 1'b1, 8'd1};
    tbl[3]  = '{8'h10, 1'b1, 8'h10, 3'd4, 1'b1, 8'd2};
    tbl[4]  = '{8'h10, 1'b1, 8'h10, 3'd4, 1'b1, 8'd3};
    tbl[5]  = '{8'h10, 1'b1, 8'h10, 3'd4, 1'b1, 8'd0};
    tbl[6]  = '{8'h04, 1'b0, 8'h04, 3'd2, 1'b1, 8'd0};
    tbl[7]  = '{8'h04, 1'b0, 8'h04, 3'd2, 1'b1, 8'd0};
    tbl[8]  = '{8'h04, 1'b0, 8'h04, 3'd2, 1'b1, 8'd0};
    tbl[9]  = '{8'h04, 1'b0, 8'h04, 3'd2, 1'b1, 8'd0};
    tbl[10] = '{8'h04, 1'b1, 8'h04, 3'd2, 1'b1, 8'd1};
    tbl[11] = '{8'h00, 1'b1, 8'h00, 3'd2, 1'b0, 8'd0};
    tbl[12] = '{8'h80, 1'b0, 8'h80, 3'd7, 1'b1, 8'd0};
    tbl[13] = '{8'h80, 1'b1, 8'h80, 3'd7, 1'b1, 8'd1};
    tbl[14] = '{8'hFF, 1'b1, 8'h80, 3'd7, 1'b1, 8'd2};

    reset = 1'b1; req = 8'h00; ready = 1'b0; req1 = 8'h00; ready1 = 1'b0;
    #3;
    chk("reset gnt",   gnt,      8'h00);
    chk("reset sel",   sel,      3'd0);
    chk("reset valid", valid,    1'b0);
    chk("reset beat",  beat_cnt, 8'd0);
    chk("reset gnt1",  gnt1,     8'h00);
    tick();
    reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      req   = tbl[i].req;
      ready = tbl[i].ready;
      tick();
      chk($sformatf("row%0d gnt", i),   gnt,      tbl[i].gnt);
      chk($sformatf("row%0d sel", i),   sel,      tbl[i].sel);
      chk($sformatf("row%0d valid", i), valid,    tbl[i].valid);
      chk($sformatf("row%0d beat", i),  beat_cnt, tbl[i].beat);
    end

    // Owner 7 drops its request alongside ready: no beat counted, pointer wraps.
    req = 8'h22; ready = 1'b1;
    #1;
    chk("drop valid", valid,    1'b0);
    chk("drop beat",  beat_cnt, 8'd2);
    tick();
    chk("wrap gnt",  gnt,      8'h02);
    chk("wrap sel",  sel,      3'd1);
    chk("wrap beat", beat_cnt, 8'd0);

    // Full contention rotates through every requester, four beats each.
    reset = 1'b1; req = 8'h00;
    tick();
    reset = 1'b0; req = 8'hFF; ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      for (int b = 0; b < 4; b++) begin
        logic [7:0] eg;
        eg = 8'h01 << (k % 8);
        tick();
        chk($sformatf("rr k%0d b%0d gnt", k, b),   gnt,      eg);
        chk($sformatf("rr k%0d b%0d beat", k, b),  beat_cnt, 8'(b));
        chk($sformatf("rr k%0d b%0d valid", k, b), valid,    1'b1);
      end
    end

    // Reset in the middle of a burst on owner 3.
    reset = 1'b1; req = 8'h00;
    tick();
    reset = 1'b0; req = 8'h08; ready = 1'b1;
    tick();
    chk("b3 gnt", gnt, 8'h08);
    tick();
    chk("b3 beat", beat_cnt, 8'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst gnt",   gnt,      8'h00);
    chk("midrst valid", valid,    1'b0);
    chk("midrst beat",  beat_cnt, 8'd0);
    chk("midrst sel",   sel,      3'd0);
    req = 8'h0C;
    tick();
    chk("inrst gnt", gnt, 8'h00);
    reset = 1'b0;
    tick();
    chk("postrst gnt",  gnt,      8'h04);
    chk("postrst sel",  sel,      3'd2);
    chk("postrst beat", beat_cnt, 8'd0);

    // MAX_BURST = 1: every accepted beat hands the bus over.
    req = 8'h00;
    req1 = 8'h03; ready1 = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk($sformatf("mb1 c%0d gnt", c),  gnt1,      (c % 2 == 0) ? 8'h01 : 8'h02);
      chk($sformatf("mb1 c%0d beat", c), beat_cnt1, 8'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/bus_arb_8.md
BUS_ARB_8 -- requirements
Module: bus_arb_8

Interface
REQ-001 SHALL provide parameter MAX_BURST, default 4, meaning the maximum number of beats one owner may transfer per grant; legal range 1..255.
REQ-002 SHALL provide port clk  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL provide port reset  input  1  reset; asynchronous and active-high.
REQ-004 SHALL provide port req  input  8  per-requester request; bit i means requester i has a beat to send.
REQ-005 SHALL provide port ready  input  1  consumer accepts the beat on the shared bus this cycle.
REQ-006 SHALL provide port gnt  output  8  one-hot grant to the current owner; all-zero when no owner.
REQ-007 SHALL provide port sel  output  3  select code for the 32-bit 8:1 shared-bus multiplexer (value i selects requester i).
REQ-008 SHALL provide port valid  output  1  beat on the shared bus is valid this cycle.
REQ-009 SHALL provide port beat_cnt  output  8  beats completed in the current grant.

Function
REQ-010 SHALL implement a two-state FSM: IDLE (no owner) and GRANT (owner held in a 3-bit register).
REQ-011 SHALL define transfer = valid AND ready; ready SHALL be ignored while valid is 0.
REQ-012 SHALL drive valid combinationally as (state == GRANT) AND req[owner]; no other path SHALL assert valid.
REQ-013 SHALL drive gnt = one-hot(owner) in GRANT and 8'h00 in IDLE, directly from registers.
REQ-014 SHALL drive sel = owner in GRANT; in IDLE sel SHALL hold the last owner value (0 after reset).
REQ-015 SHALL maintain a 3-bit round-robin pointer ptr; winner = first i with req[i]=1 scanning ptr, ptr+1, ..., ptr+7 modulo 8.
REQ-016 IDLE: if any req bit is 1 at a clock edge, SHALL enter GRANT with owner = winner; grant visible one cycle after req is sampled; otherwise remain IDLE.
REQ-017 GRANT: on transfer with beat_cnt < MAX_BURST-1, SHALL increment beat_cnt and keep owner.
REQ-018 GRANT: SHALL release the owner at the clock edge when req[owner] = 0, or when transfer occurs with beat_cnt = MAX_BURST-1.
REQ-019 On release, SHALL set ptr = owner+1 (mod 8, 7 wraps to 0) and re-arbitrate in the same edge using that ptr and the current req.
REQ-020 On release with any req bit set, SHALL go directly to GRANT with the new winner (no idle cycle) and beat_cnt = 0; otherwise SHALL go to IDLE with beat_cnt = 0.
REQ-021 After a burst-limit release, the previous owner SHALL be re-granted only when no other req bit is set, which follows from REQ-019.
REQ-022 Requests from non-owners SHALL NOT affect owner, valid, or beat_cnt while the current grant is held.
REQ-023 If req[owner] drops in the same cycle as ready=1, SHALL count no transfer, because valid is 0.
REQ-024 With MAX_BURST = 1, every transfer SHALL release the grant.
REQ-025 beat_cnt SHALL never reach MAX_BURST and SHALL never wrap.

Reset
REQ-026 While reset = 1, SHALL immediately force state = IDLE, owner = 0, ptr = 0, beat_cnt = 0, so that gnt = 8'h00, sel = 0, valid = 0, independent of clk.
REQ-027 Reset asserted mid-burst SHALL abandon the burst with no further valid; after deassertion, arbitration SHALL restart from ptr = 0.
REQ-028 The first rising edge after reset deassertion SHALL perform a normal IDLE evaluation.

Verification
REQ-029 SHALL cover: reset, then req=8'h10, ready=1 held -> gnt=8'h10 and sel=4 one cycle later; 4 transfers with beat_cnt 0,1,2,3; then release, then re-grant to 4 with beat_cnt=0.
REQ-030 SHALL cover: req=8'hFF and ready=1 constant with MAX_BURST=4 -> owners 0,1,...,7,0 in order, 4 beats each, no idle cycle between grants.
REQ-031 SHALL cover: owner 2 and ready=0 for 3 cycles -> valid=1, beat_cnt stays 0, gnt unchanged; ready=1 -> beat_cnt=1.
REQ-032 SHALL cover: owner 7, req[7] drops while req[1] and req[5] are high -> next owner 1 (ptr wraps to 0), no transfer counted in the drop cycle.
REQ-033 SHALL cover: reset asserted mid-edge during a burst on owner 3 -> gnt=0, valid=0, beat_cnt=0 immediately; after release with req=8'h0C -> owner 2.
REQ-034 SHALL cover: MAX_BURST=1 with req=8'h03 and ready=1 -> gnt alternates 8'h01, 8'h02 every cycle.
